pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles spent waiting for dmem_ack (range 1..255).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 ex_rd  input  5  destination register of the instruction in EX.
REQ-006 ex_mem_read  input  1  the instruction in EX is a load.
REQ-007 ex_branch_taken  input  1  the branch or jump in EX resolved as taken.
REQ-008 mem_mem_read, mem_mem_write  input  1 each  the instruction in MEM is a load or a store.
REQ-009 dmem_ack  input  1  data memory completes the current access this cycle.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  output  1 each  pipeline register load enables.
REQ-011 if_id_flush, id_ex_flush, mem_wb_bubble  output  1 each  force the named register to a NOP (control bits zero) on its next load.
REQ-012 dmem_req  output  1  data memory access request.
REQ-013 mem_err  output  1  sticky flag: a memory access timed out.
REQ-014 stall_cycles, flush_count  output  32 each  performance counters (see Configuration).

Function
REQ-015 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-016 mem_access SHALL be defined as mem_mem_read OR mem_mem_write.
REQ-017 dmem_req SHALL be asserted when (RUN and mem_access) or in MEM_WAIT; it is combinational from state and inputs.
REQ-018 mem_stall SHALL be defined as dmem_req AND NOT dmem_ack.
REQ-019 Transitions: RUN goes to MEM_WAIT on mem_stall. MEM_WAIT goes to RUN on dmem_ack or on timeout. All other cases hold state.
REQ-020 On a RUN access acknowledged in the same cycle, the pipeline SHALL see zero stall cycles.
REQ-021 While mem_stall is asserted:
  - pc_write, if_id_write, id_ex_write and ex_mem_write SHALL be 0;
  - mem_wb_write SHALL be 1 and mem_wb_bubble SHALL be 1;
  - all flushes SHALL be 0, so a pending branch or load-use is re-evaluated after release.
REQ-022 A 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without dmem_ack.
REQ-023 When the wait counter equals MEM_TIMEOUT-1 and dmem_ack is low, the FSM SHALL go to RUN and set mem_err. That cycle SHALL release the pipeline with mem_wb_bubble=1.
REQ-024 mem_err SHALL clear only on reset.
REQ-025 A load-use hazard SHALL be defined as ex_mem_read AND ex_rd != 0 AND (ex_rd == id_rs1 OR ex_rd == id_rs2).
REQ-026 On a load-use hazard without mem_stall: pc_write=0, if_id_write=0, id_ex_flush=1; all other enables are 1.
REQ-027 On ex_branch_taken without mem_stall: if_id_flush=1 and id_ex_flush=1, with all enables 1. This SHALL take priority over a load-use hazard in the same cycle.
REQ-028 Priority SHALL be: mem_stall, then branch, then load-use, then normal operation (all enables 1, flushes 0, bubble 0).
REQ-029 If dmem_ack arrives while dmem_req is 0, it SHALL be ignored.

Reset
REQ-030 While reset is high:
  - all enables, flushes, bubble and dmem_req SHALL be 0;
  - at the clock edge, the state SHALL go to RUN, and the wait counter, mem_err and the counters SHALL clear.
REQ-031 Reset asserted in MEM_WAIT SHALL abandon the access; dmem_req SHALL be 0 in the first cycle after reset deasserts unless mem_access is high.

Configuration
REQ-032 With PIPE_PERF_CNT_EN defined:
  - stall_cycles SHALL increment on each cycle where mem_stall is high or a load-use stall occurs;
  - flush_count SHALL increment on each taken-branch flush;
  - both counters SHALL wrap modulo 2^32.
REQ-033 Without PIPE_PERF_CNT_EN, both ports SHALL remain present and be tied to 0, with no counter logic.

Verification
REQ-034 Load with dmem_ack low for 3 cycles, then high -> dmem_req high for 4 cycles; pc_write=0 for 3 cycles; mem_wb_bubble=1 for 3 cycles; stall_cycles=3.
REQ-035 ex_mem_read=1, ex_rd=5, id_rs2=5, no memory access -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1. With ex_rd=0 -> no stall.
REQ-036 ex_branch_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count increments by 1.
REQ-037 MEM_TIMEOUT=4 with dmem_ack held low -> return to RUN after 4 wait cycles; mem_err=1 and stays 1 until reset.
REQ-038 Reset pulsed for 1 cycle during MEM_WAIT -> state RUN, dmem_req=0, mem_err=0, counters 0.
REQ-039 Branch taken while mem_stall is high -> no flush during the stall; the flush asserts in the release cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline. It handles
//   data-memory wait states (with a timeout), load-use stalls and taken-branch
//   flushes, and drives the pipeline register enables, flushes and bubble.
//
// Parameters
//   MEM_TIMEOUT      max cycles spent waiting for dmem_ack (1..255)
//
// Optional feature macro
//   PIPE_PERF_CNT_EN when defined, stall_cycles / flush_count count events;
//                    otherwise both ports are tied to zero.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   id_rs1, id_rs2               source registers of the instruction in ID
//   ex_rd, ex_mem_read           destination / load flag of the instruction in EX
//   ex_branch_taken              branch or jump in EX resolved as taken
//   mem_mem_read, mem_mem_write  instruction in MEM is a load / store
//   dmem_ack                     data memory completes the access this cycle
//   pc_write .. mem_wb_write     pipeline register load enables
//   if_id_flush, id_ex_flush     load a NOP into IF/ID, ID/EX
//   mem_wb_bubble                load a NOP into MEM/WB
//   dmem_req                     data memory access request
//   mem_err                      sticky timeout flag
//   stall_cycles, flush_count    performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_branch_taken,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic        dmem_ack,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_write,
   output logic        ex_mem_write,
   output logic        mem_wb_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mem_wb_bubble,
   output logic        dmem_req,
   output logic        mem_err,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [0:0] state_reg, state_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;
   logic       mem_err_reg, mem_err_next;

   logic mem_access;
   logic ack_missing;
   logic timeout;
   logic mem_stall;
   logic load_use;

   // Request / stall qualification
   always_comb begin
      mem_access  = mem_mem_read | mem_mem_write;
      dmem_req    = !reset && ((state_reg == ST_RUN && mem_access) || state_reg == ST_MEM_WAIT);
      // dmem_ack is only meaningful while a request is outstanding
      ack_missing = dmem_req && !dmem_ack;
      timeout     = dmem_req && (state_reg == ST_MEM_WAIT) && !dmem_ack &&
                    (wait_cnt_reg == TIMEOUT_LAST);
      // The timeout cycle releases the pipeline, so it is not a stall cycle
      mem_stall   = ack_missing && !timeout;
      load_use    = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   end

   // Pipeline control outputs, priority: mem stall > branch > load-use > normal
   always_comb begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      if (!reset) begin
         if (mem_stall) begin
            // Freeze the front, drain a NOP into WB; flushes wait for release
            mem_wb_write  = 1'b1;
            mem_wb_bubble = 1'b1;
         end else begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            mem_wb_write  = 1'b1;
            // A timed-out access has no valid data to write back
            mem_wb_bubble = timeout;
            if (ex_branch_taken) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
      end
   end

   // FSM and wait counter
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      mem_err_next  = mem_err_reg;
      case (state_reg)
         ST_RUN: begin
            if (ack_missing) begin
               state_next    = ST_MEM_WAIT;
               wait_cnt_next = 8'd0;
            end
         end
         default: begin
            if (dmem_ack) begin
               state_next = ST_RUN;
            end else if (timeout) begin
               state_next   = ST_RUN;
               mem_err_next = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= ST_RUN;
         wait_cnt_reg <= 8'd0;
         mem_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         mem_err_reg  <= mem_err_next;
      end
   end

   assign mem_err = mem_err_reg;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_reg;
   logic [31:0] flush_count_reg;
   logic        stall_evt;
   logic        flush_evt;

   // Events are counted only when they actually take effect on the pipeline
   assign stall_evt = mem_stall || (!ex_branch_taken && load_use);
   assign flush_evt = !mem_stall && ex_branch_taken;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles_reg <= 32'd0;
         flush_count_reg  <= 32'd0;
      end else begin
         if (stall_evt) stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (flush_evt) flush_count_reg  <= flush_count_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl (MEM_TIMEOUT = 4). Single-cycle hazard
//   cases come from a vector table; memory wait, timeout and reset-in-wait
//   are hand-written sequences. Inputs change on the falling edge and outputs
//   are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        ex_mem_read, ex_branch_taken;
   logic        mem_mem_read, mem_mem_write, dmem_ack;
   logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic        if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req, mem_err;
   logic [31:0] stall_cycles, flush_count;

   int tests  = 0;
   int failed = 0;

   pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .mem_mem_read    (mem_mem_read),
      .mem_mem_write   (mem_mem_write),
      .dmem_ack        (dmem_ack),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .id_ex_write     (id_ex_write),
      .ex_mem_write    (ex_mem_write),
      .mem_wb_write    (mem_wb_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .mem_wb_bubble   (mem_wb_bubble),
      .dmem_req        (dmem_req),
      .mem_err         (mem_err),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   always #5 clock = ~clock;

   // Expected-output vector layout:
   // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_fl, id_ex_fl, bubble, req}
   localparam logic [8:0] V_IDLE    = 9'b11111_00_0_0;
   localparam logic [8:0] V_LDUSE   = 9'b00111_01_0_0;
   localparam logic [8:0] V_BRANCH  = 9'b11111_11_0_0;
   localparam logic [8:0] V_STALL   = 9'b00001_00_1_1;
   localparam logic [8:0] V_ZERO    = 9'b00000_00_0_0;

   typedef struct {
      logic       exmr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       br;
      logic       mrd;
      logic       mwr;
      logic       ack;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [8:0] outv();
      return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
              if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: %h", name, act);
      end
   endtask

   task automatic set_in(input logic exmr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic mrd,
                         input logic mwr, input logic ack);
      ex_mem_read     = exmr;
      ex_rd           = rd;
      id_rs1          = rs1;
      id_rs2          = rs2;
      ex_branch_taken = br;
      mem_mem_read    = mrd;
      mem_mem_write   = mwr;
      dmem_ack        = ack;
   endtask

   // One reset cycle with a load pending; all outputs must stay low
   task automatic do_reset(input string tag);
      @(negedge clock);
      reset = 1'b1;
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      check({tag, " outs in reset"}, 32'(outv()), 32'(V_ZERO));
      @(negedge clock);
      reset = 1'b0;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
      vecs[1]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, V_LDUSE};
      vecs[2]  = '{1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, V_LDUSE};
      vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
      vecs[4]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
      vecs[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, V_BRANCH};
      vecs[6]  = '{1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, V_BRANCH};
      vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 9'b11111_00_0_1};
      vecs[8]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b00111_01_0_1};
      vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, V_IDLE};
      vecs[10] = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};

      // Reset state
      @(negedge clock);
      #1;
      check("reset outs", 32'(outv()), 32'(V_ZERO));
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset mem_err", 32'(mem_err), 32'd0);
      check("reset stall_cycles", stall_cycles, 32'd0);
      check("reset flush_count", flush_count, 32'd0);

      // Single-cycle vectors, all in RUN
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         set_in(vecs[i].exmr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].br, vecs[i].mrd, vecs[i].mwr, vecs[i].ack);
         #1;
         check($sformatf("vec%0d", i), 32'(outv()), 32'(vecs[i].exp));
      end
      @(negedge clock);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("table stall_cycles", stall_cycles, PERF ? 32'd3 : 32'd0);
      check("table flush_count", flush_count, PERF ? 32'd2 : 32'd0);

      // Load acked after 3 low cycles, branch pending throughout the stall
      do_reset("wait");
      for (int c = 0; c < 3; c++) begin
         set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         #1;
         check($sformatf("wait stall c%0d", c), 32'(outv()), 32'(V_STALL));
         @(negedge clock);
      end
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      check("wait release", 32'(outv()), 32'(9'b11111_11_0_1));
      @(negedge clock);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("wait after", 32'(outv()), 32'(V_IDLE));
      check("wait stall_cycles", stall_cycles, PERF ? 32'd3 : 32'd0);
      check("wait flush_count", flush_count, PERF ? 32'd1 : 32'd0);

      // Timeout: ack never arrives, MEM_TIMEOUT = 4
      do_reset("tmo");
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("tmo stall c%0d", c), 32'(outv()), 32'(V_STALL));
         check($sformatf("tmo err c%0d", c), 32'(mem_err), 32'd0);
         @(negedge clock);
      end
      #1;
      check("tmo release", 32'(outv()), 32'(9'b11111_00_1_1));
      @(negedge clock);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("tmo after", 32'(outv()), 32'(V_IDLE));
      check("tmo err set", 32'(mem_err), 32'd1);
      check("tmo stall_cycles", stall_cycles, PERF ? 32'd4 : 32'd0);
      repeat (3) @(negedge clock);
      #1;
      check("tmo err sticky", 32'(mem_err), 32'd1);

      // Reset pulsed while in MEM_WAIT
      @(negedge clock);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      #1;
      check("rstw in wait", 32'(outv()), 32'(V_STALL));
      do_reset("rstw");
      check("rstw after", 32'(outv()), 32'(V_IDLE));
      check("rstw mem_err", 32'(mem_err), 32'd0);
      check("rstw stall_cycles", stall_cycles, 32'd0);
      check("rstw flush_count", flush_count, 32'd0);
      @(negedge clock);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      check("rstw run access", 32'(outv()), 32'(9'b11111_00_0_1));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
